// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array result drain.
//   LANE_W        width of one partial-product lane coming out of the MAC array
//   DEFAULT_N     default lane count, matching the MAC array width
//   drain_state_e drain controller states
//   clog2_min1    clog2 that never returns zero, so it can size index ports
package mac_pkg;

  localparam int LANE_W    = 16;
  localparam int DEFAULT_N = 144;

  // IDLE : shadow bank empty
  // DRAIN: shadow bank streaming out
  // FULL : accumulator holds a finished tile waiting for the shadow bank
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } drain_state_e;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/mac_lane_acc.sv
// Single-lane accumulate/clear/transfer cell holding both sums of one lane.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   acc_add         add the sign-extended partials into the accumulators
//   acc_clr         clear the accumulators (wins over acc_add)
//   sh_load         load the shadow registers
//   sh_from_sum     shadow source: 1 = acc + current partial, 0 = acc alone
//   in_1, in_2      signed 16-bit partials of this lane
//   shadow_1/2      shadow register contents, read by the beat mux
module mac_lane_acc
  import mac_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_add,
  input  logic                     acc_clr,
  input  logic                     sh_load,
  input  logic                     sh_from_sum,
  input  logic signed [LANE_W-1:0] in_1,
  input  logic signed [LANE_W-1:0] in_2,
  output logic        [ACC_W-1:0]  shadow_1,
  output logic        [ACC_W-1:0]  shadow_2
);

  logic        [ACC_W-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
  logic        [ACC_W-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic signed [ACC_W-1:0] ext_1, ext_2;
  logic        [ACC_W-1:0] sum_1, sum_2;

  // Signed assignment to the wider signed net sign-extends; the add wraps
  // naturally at ACC_W bits.
  always_comb begin
    ext_1 = in_1;
    ext_2 = in_2;
    sum_1 = acc1_q + ext_1;
    sum_2 = acc2_q + ext_2;

    acc1_d = acc1_q;
    acc2_d = acc2_q;
    if (acc_clr) begin
      acc1_d = '0;
      acc2_d = '0;
    end else if (acc_add) begin
      acc1_d = sum_1;
      acc2_d = sum_2;
    end

    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (sh_load) begin
      sh1_d = sh_from_sum ? sum_1 : acc1_q;
      sh2_d = sh_from_sum ? sum_2 : acc2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
      sh1_q  <= '0;
      sh2_q  <= '0;
    end else begin
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
    end
  end

  assign shadow_1 = sh1_q;
  assign shadow_2 = sh2_q;

endmodule

// File: rtl/mac_result_drain.sv
// Consumer end of the parallel MAC array. Accumulates the N-lane partial
// vectors of a tile, moves finished tiles into a shadow bank and streams the
// shadow bank out L lanes per beat while the next tile accumulates.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready/in_last   partial-vector handshake, in_last ends a tile
//   in_1, in_2                  N signed 16-bit lanes each
//   out_valid/out_ready         output beat handshake
//   out_last                    final beat of a tile
//   out_1, out_2                L lanes of ACC_W bits of the current beat
//   out_beat                    index of the current beat within the tile
module mac_result_drain
  import mac_pkg::*;
#(
  parameter  int N      = DEFAULT_N,
  parameter  int L      = 8,
  parameter  int ACC_W  = 32,
  localparam int BEATS  = N / L,
  localparam int BEAT_W = clog2_min1(N / L)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANE_W*N-1:0]   in_1,
  input  logic [LANE_W*N-1:0]   in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [L*ACC_W-1:0]    out_1,
  output logic [L*ACC_W-1:0]    out_2,
  output logic [BEAT_W-1:0]     out_beat
);

  localparam int              IDX_W     = clog2_min1(N);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  generate
    if (N % L != 0) begin : g_bad_lane_split
      $error("mac_result_drain: N must be a multiple of L");
    end
  endgenerate

  drain_state_e          state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  accept, drive, final_beat, final_drive;
  logic                  acc_add, acc_clr, sh_load, sh_from_sum;
  logic [ACC_W-1:0]      shadow_1 [N];
  logic [ACC_W-1:0]      shadow_2 [N];

  for (genvar k = 0; k < N; k++) begin : g_lane
    mac_lane_acc #(
      .ACC_W(ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .acc_add    (acc_add),
      .acc_clr    (acc_clr),
      .sh_load    (sh_load),
      .sh_from_sum(sh_from_sum),
      .in_1       (in_1[LANE_W*k +: LANE_W]),
      .in_2       (in_2[LANE_W*k +: LANE_W]),
      .shadow_1   (shadow_1[k]),
      .shadow_2   (shadow_2[k])
    );
  end

  // Handshake flags depend on registered state only.
  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != IDLE);
  assign accept      = in_valid && in_ready;
  assign drive       = out_valid && out_ready;
  assign final_beat  = (beat_q == LAST_BEAT);
  assign final_drive = drive && final_beat;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_add     = 1'b0;
    acc_clr     = 1'b0;
    sh_load     = 1'b0;
    sh_from_sum = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && in_last) begin
          sh_load     = 1'b1;
          sh_from_sum = 1'b1;
          acc_clr     = 1'b1;
          beat_d      = '0;
          state_d     = DRAIN;
        end else if (accept) begin
          acc_add = 1'b1;
        end
      end

      DRAIN: begin
        if (drive && !final_beat) begin
          beat_d = beat_q + 1'b1;
        end
        if (accept && in_last && final_drive) begin
          // Back-to-back tiles: the new tile goes straight to the shadow bank.
          sh_load     = 1'b1;
          sh_from_sum = 1'b1;
          acc_clr     = 1'b1;
          beat_d      = '0;
        end else if (accept && in_last) begin
          // Finished tile parks in the accumulator until the shadow frees up.
          acc_add = 1'b1;
          state_d = FULL;
        end else begin
          acc_add = accept;
          if (final_drive) begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end

      FULL: begin
        if (drive && !final_beat) begin
          beat_d = beat_q + 1'b1;
        end
        if (final_drive) begin
          sh_load     = 1'b1;
          sh_from_sum = 1'b0;
          acc_clr     = 1'b1;
          beat_d      = '0;
          state_d     = DRAIN;
        end
      end

      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Beat mux; the outputs only move when beat_q or the shadow bank move,
  // which happens only on a drive, so they hold during back-pressure.
  always_comb begin
    logic [IDX_W-1:0] idx;
    out_1    = '0;
    out_2    = '0;
    out_last = 1'b0;
    out_beat = beat_q;
    idx      = '0;
    if (state_q != IDLE) begin
      out_last = final_beat;
      for (int j = 0; j < L; j++) begin
        idx = IDX_W'(int'(beat_q) * L + j);
        out_1[ACC_W*j +: ACC_W] = shadow_1[idx];
        out_2[ACC_W*j +: ACC_W] = shadow_2[idx];
      end
    end
  end

endmodule
